// File: rtl/spi_oversampling_top.sv
// spi_oversampling_top
// SPI slave front-end (mode 0, MSB first) running entirely in the clk_in
// domain. SCK, CS and MOSI are synchronised through equal-depth flop chains,
// then MOSI is sampled a fixed number of clk_in cycles after each SCK rise so
// that MOSI skew relative to SCK is tolerated. Each received word is echoed
// on MISO in the next frame, and every frame is audited when CS deasserts.
//
// Ports:
//   clk_in   in   system clock (25 MHz), all logic on its rising edge
//   rst      in   synchronous, active-low reset
//   spi_cs   in   chip select, active low, asynchronous
//   spi_sck  in   SPI clock, idle low, asynchronous
//   spi_mosi in   serial data in, asynchronous
//   spi_miso out  serial data out, registered
//   led      out  audit result: led[0] = frame OK, led[1] = frame error
//
// Optional feature: define SPI_MAJORITY_VOTE_EN to capture each bit as the
// majority of three MOSI samples (counter values SAMPLE_DELAY-1, SAMPLE_DELAY
// and SAMPLE_DELAY+1), which adds one cycle of capture latency.

module spi_oversampling_top #(
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DELAY = 4,
  parameter int DATA_W       = 8
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [1:0] led
);

`ifdef SPI_MAJORITY_VOTE_EN
  localparam int CAPTURE_AT = SAMPLE_DELAY + 1;
`else
  localparam int CAPTURE_AT = SAMPLE_DELAY;
`endif
  localparam int CNT_W = $clog2(CAPTURE_AT + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       sample_delay_cnt_q, sample_delay_cnt_d;
  logic [DATA_W-1:0]      shift_reg_q, shift_reg_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      rx_byte_q, rx_byte_d;
  logic [DATA_W-1:0]      tx_reg_q, tx_reg_d;
  logic                   miso_q, miso_d;
  logic [1:0]             led_q, led_d;
  logic                   word_seen_q, word_seen_d;
`ifdef SPI_MAJORITY_VOTE_EN
  logic [1:0]             vote_q, vote_d;
`endif

  logic             sck_s, cs_s, mosi_s;
  logic             sck_rise, sck_fall, cs_rise, cs_fall;
  logic             cnt_active, at_capture;
  logic             capture, capture_bit;
  logic [BIT_W-1:0] bit_next;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign cnt_active = (sample_delay_cnt_q != '0);
  assign at_capture = (sample_delay_cnt_q == CNT_W'(CAPTURE_AT));

  // Synchroniser chains and the extra delayed copies used for edge detection.
  // All three inputs share the same depth so SCK/MOSI skew is preserved.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
  end

`ifdef SPI_MAJORITY_VOTE_EN
  // Record the two early votes; the third vote is the live sample at capture.
  // A capture forced before the window completes falls back to the live
  // sample, which is also the tie-breaker when only two votes exist.
  always_comb begin
    vote_d = vote_q;
    if (sample_delay_cnt_q == CNT_W'(SAMPLE_DELAY - 1)) vote_d[0] = mosi_s;
    if (sample_delay_cnt_q == CNT_W'(SAMPLE_DELAY))     vote_d[1] = mosi_s;
    if (at_capture)
      capture_bit = (vote_q[0] & vote_q[1]) | (vote_q[0] & mosi_s) | (vote_q[1] & mosi_s);
    else
      capture_bit = mosi_s;
  end
`else
  assign capture_bit = mosi_s;
`endif

  // Sampling, word assembly, transmit shifting and the end-of-frame audit.
  // The capture is resolved before the audit so a bit still in flight at the
  // CS rise is counted.
  always_comb begin
    sample_delay_cnt_d = sample_delay_cnt_q;
    shift_reg_d        = shift_reg_q;
    bit_cnt_d          = bit_cnt_q;
    rx_byte_d          = rx_byte_q;
    tx_reg_d           = tx_reg_q;
    miso_d             = miso_q;
    led_d              = led_q;
    word_seen_d        = word_seen_q;
    capture            = 1'b0;
    bit_next           = bit_cnt_q + BIT_W'(1);

    if (cs_fall) begin
      sample_delay_cnt_d = '0;
      bit_cnt_d          = '0;
      word_seen_d        = 1'b0;
      tx_reg_d           = rx_byte_q;
      miso_d             = rx_byte_q[DATA_W-1];
    end else if (cs_s) begin
      sample_delay_cnt_d = '0;
      miso_d             = 1'b0;
      capture            = cs_rise & cnt_active;
    end else begin
      // A new SCK rise while a sample is pending commits that sample now.
      if (sck_rise) begin
        capture            = cnt_active;
        sample_delay_cnt_d = CNT_W'(1);
      end else if (at_capture) begin
        capture            = 1'b1;
        sample_delay_cnt_d = '0;
      end else if (cnt_active) begin
        sample_delay_cnt_d = sample_delay_cnt_q + CNT_W'(1);
      end
      if (sck_fall) begin
        tx_reg_d = tx_reg_q << 1;
        miso_d   = tx_reg_q[DATA_W-2];
      end
    end

    if (capture) begin
      shift_reg_d = (shift_reg_q << 1) | DATA_W'(capture_bit);
      if (bit_next == BIT_W'(DATA_W)) begin
        rx_byte_d   = shift_reg_d;
        bit_cnt_d   = '0;
        word_seen_d = 1'b1;
      end else begin
        bit_cnt_d = bit_next;
      end
    end

    if (cs_rise) begin
      if (bit_cnt_d != '0)  led_d = 2'b10;
      else if (word_seen_d) led_d = 2'b01;
      else                  led_d = 2'b00;
    end
  end

  // State registers; reset returns every synchroniser to the idle bus level.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      sck_sync_q         <= '0;
      cs_sync_q          <= '1;
      mosi_sync_q        <= '0;
      sck_prev_q         <= 1'b0;
      cs_prev_q          <= 1'b1;
      sample_delay_cnt_q <= '0;
      shift_reg_q        <= '0;
      bit_cnt_q          <= '0;
      rx_byte_q          <= '0;
      tx_reg_q           <= '0;
      miso_q             <= 1'b0;
      led_q              <= 2'b00;
      word_seen_q        <= 1'b0;
`ifdef SPI_MAJORITY_VOTE_EN
      vote_q             <= '0;
`endif
    end else begin
      sck_sync_q         <= sck_sync_d;
      cs_sync_q          <= cs_sync_d;
      mosi_sync_q        <= mosi_sync_d;
      sck_prev_q         <= sck_prev_d;
      cs_prev_q          <= cs_prev_d;
      sample_delay_cnt_q <= sample_delay_cnt_d;
      shift_reg_q        <= shift_reg_d;
      bit_cnt_q          <= bit_cnt_d;
      rx_byte_q          <= rx_byte_d;
      tx_reg_q           <= tx_reg_d;
      miso_q             <= miso_d;
      led_q              <= led_d;
      word_seen_q        <= word_seen_d;
`ifdef SPI_MAJORITY_VOTE_EN
      vote_q             <= vote_d;
`endif
    end
  end

  assign spi_miso = miso_q;
  assign led      = led_q;

endmodule

// File: tb/tb_spi_oversampling_top.sv
// Directed testbench for spi_oversampling_top: drives SPI frames with MOSI
// skewed 20 ns after each SCK rise and 400 ns half-periods, then compares
// outputs and key internal registers against hand-computed values.

module tb_spi_oversampling_top;

  logic       clk_in   = 1'b0;
  logic       rst      = 1'b0;
  logic       spi_cs   = 1'b1;
  logic       spi_sck  = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic [1:0] led;

  int tests_run    = 0;
  int tests_failed = 0;

  spi_oversampling_top dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .spi_cs   (spi_cs),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .led      (led)
  );

  // 25 MHz system clock
  always #20 clk_in = ~clk_in;

  // One SCK period: MOSI settles 20 ns after the rise; optionally MOSI is
  // flipped late in the high phase, well after the capture point.
  task automatic send_bit(input logic b, input logic glitch);
    spi_sck = 1'b1;
    #20 spi_mosi = b;
    #360 if (glitch) spi_mosi = ~b;
    #20 spi_sck = 1'b0;
    #400;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic glitch);
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitch);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #100;
    @(negedge clk_in);
    tests_run++;
    if (spi_miso !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_miso: got %b expected 0", spi_miso); end
    tests_run++;
    if (led !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_led: got %b expected 00", led); end
    tests_run++;
    if (int'(dut.sample_delay_cnt_q) !== 0) begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", dut.sample_delay_cnt_q); end
    tests_run++;
    if (int'(dut.bit_cnt_q) !== 0) begin tests_failed++; $display("[TB] FAIL reset_bitcnt: got %0d expected 0", dut.bit_cnt_q); end
    tests_run++;
    if (dut.rx_byte_q !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rx: got %h expected 00", dut.rx_byte_q); end
    rst = 1'b1;
    #200;
  endtask

  task automatic test_skew_capture;
    bit found;
    spi_cs = 1'b0;
    #200;
    spi_sck = 1'b1;
    #20 spi_mosi = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (int'(dut.sample_delay_cnt_q) == 1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL skew_cnt_start: got %0d expected 1 within 20 cycles", dut.sample_delay_cnt_q);
    end else begin
`ifdef SPI_MAJORITY_VOTE_EN
      for (int k = 2; k <= 5; k++) begin
`else
      for (int k = 2; k <= 4; k++) begin
`endif
        @(negedge clk_in);
        tests_run++;
        if (int'(dut.sample_delay_cnt_q) !== k) begin
          tests_failed++;
          $display("[TB] FAIL skew_cnt_%0d: got %0d expected %0d", k, dut.sample_delay_cnt_q, k);
        end
      end
      @(negedge clk_in);
      tests_run++;
      if (int'(dut.sample_delay_cnt_q) !== 0) begin tests_failed++; $display("[TB] FAIL skew_cnt_idle: got %0d expected 0", dut.sample_delay_cnt_q); end
      tests_run++;
      if (dut.shift_reg_q[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL skew_shift0: got %b expected 1", dut.shift_reg_q[0]); end
      tests_run++;
      if (int'(dut.bit_cnt_q) !== 1) begin tests_failed++; $display("[TB] FAIL skew_bitcnt: got %0d expected 1", dut.bit_cnt_q); end
    end
    #100 spi_sck = 1'b0;
    #400 spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b10) begin tests_failed++; $display("[TB] FAIL skew_led: got %b expected 10", led); end
  endtask

  task automatic test_full_byte;
    spi_cs = 1'b0;
    #400;
    send_byte(8'hA5, 1'b0);
    #200;
    @(negedge clk_in);
    tests_run++;
    if (dut.rx_byte_q !== 8'hA5) begin tests_failed++; $display("[TB] FAIL byte_rx: got %h expected a5", dut.rx_byte_q); end
    tests_run++;
    if (int'(dut.bit_cnt_q) !== 0) begin tests_failed++; $display("[TB] FAIL byte_bitcnt: got %0d expected 0", dut.bit_cnt_q); end
    spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b01) begin tests_failed++; $display("[TB] FAIL byte_led: got %b expected 01", led); end
  endtask

  task automatic test_echo;
    logic [7:0] expect_tx;
    logic [7:0] send_rx;
    expect_tx = 8'hA5;
    send_rx   = 8'h3C;
    spi_cs = 1'b0;
    #400;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk_in);
      tests_run++;
      if (spi_miso !== expect_tx[i]) begin
        tests_failed++;
        $display("[TB] FAIL echo_bit%0d: got %b expected %b", i, spi_miso, expect_tx[i]);
      end
      send_bit(send_rx[i], 1'b0);
    end
    #200;
    @(negedge clk_in);
    tests_run++;
    if (dut.rx_byte_q !== 8'h3C) begin tests_failed++; $display("[TB] FAIL echo_rx: got %h expected 3c", dut.rx_byte_q); end
    spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (spi_miso !== 1'b0) begin tests_failed++; $display("[TB] FAIL echo_miso_idle: got %b expected 0", spi_miso); end
    tests_run++;
    if (led !== 2'b01) begin tests_failed++; $display("[TB] FAIL echo_led: got %b expected 01", led); end
  endtask

  task automatic test_late_glitch;
    logic [7:0] v;
    v = 8'hC3;
    spi_cs = 1'b0;
    #400;
    send_bit(v[7], 1'b1);
    @(negedge clk_in);
    tests_run++;
    if (dut.shift_reg_q[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL glitch_first_bit: got %b expected 1", dut.shift_reg_q[0]); end
    for (int i = 6; i >= 0; i--) send_bit(v[i], 1'b1);
    #200;
    @(negedge clk_in);
    tests_run++;
    if (dut.rx_byte_q !== 8'hC3) begin tests_failed++; $display("[TB] FAIL glitch_rx: got %h expected c3", dut.rx_byte_q); end
    spi_cs = 1'b1;
    #400;
  endtask

  task automatic test_reset_mid_frame;
    spi_cs = 1'b0;
    #400;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk_in);
    tests_run++;
    if (int'(dut.bit_cnt_q) !== 3) begin tests_failed++; $display("[TB] FAIL midrst_pre_bitcnt: got %0d expected 3", dut.bit_cnt_q); end
    rst = 1'b0;
    #100;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrst_led: got %b expected 00", led); end
    tests_run++;
    if (spi_miso !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_miso: got %b expected 0", spi_miso); end
    tests_run++;
    if (int'(dut.bit_cnt_q) !== 0) begin tests_failed++; $display("[TB] FAIL midrst_bitcnt: got %0d expected 0", dut.bit_cnt_q); end
    tests_run++;
    if (dut.shift_reg_q !== 8'h00) begin tests_failed++; $display("[TB] FAIL midrst_shift: got %h expected 00", dut.shift_reg_q); end
    tests_run++;
    if (dut.rx_byte_q !== 8'h00) begin tests_failed++; $display("[TB] FAIL midrst_rx: got %h expected 00", dut.rx_byte_q); end
    rst = 1'b1;
    #200;
    spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b00) begin tests_failed++; $display("[TB] FAIL midrst_no_audit: got %b expected 00", led); end
    spi_cs = 1'b0;
    #400;
    send_byte(8'h5A, 1'b0);
    spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (dut.rx_byte_q !== 8'h5A) begin tests_failed++; $display("[TB] FAIL midrst_next_rx: got %h expected 5a", dut.rx_byte_q); end
    tests_run++;
    if (led !== 2'b01) begin tests_failed++; $display("[TB] FAIL midrst_next_led: got %b expected 01", led); end
  endtask

  task automatic test_empty_frame;
    spi_cs = 1'b0;
    #400 spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b00) begin tests_failed++; $display("[TB] FAIL empty_led: got %b expected 00", led); end
    spi_cs = 1'b0;
    #400;
    send_bit(1'b1, 1'b0);
    spi_cs = 1'b1;
    #400;
    @(negedge clk_in);
    tests_run++;
    if (led !== 2'b10) begin tests_failed++; $display("[TB] FAIL onebit_led: got %b expected 10", led); end
  endtask

  initial begin
    test_reset;
    test_skew_capture;
    test_full_byte;
    test_echo;
    test_late_glitch;
    test_reset_mid_frame;
    test_empty_frame;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_oversampling_top.md
Name: spi_oversampling_top

Overview:
- SPI slave front-end (mode 0, MSB first) for a 25 MHz FPGA clock domain.
- SCK, CS and MOSI are synchronised, then MOSI is sampled a fixed number of system clocks after each SCK rising edge, near the bit centre, so MOSI skew after SCK is tolerated.
- Received bytes are echoed on MISO in the next frame.
- Frame integrity is audited when CS deasserts and reported on two LEDs.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for spi_sck, spi_cs and spi_mosi.
- SAMPLE_DELAY, 4, clk_in cycles from synchronised SCK rising edge to MOSI capture.
- DATA_W, 8, bits per word.

Ports:
- clk_in  input  1  system clock, 25 MHz; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- spi_cs  input  1  chip select, active low, asynchronous to clk_in.
- spi_sck  input  1  SPI clock, idle low, asynchronous.
- spi_mosi  input  1  serial data in, asynchronous.
- spi_miso  output  1  serial data out, registered.
- led  output  2  audit result: led[0] = frame OK, led[1] = frame error.

Behaviour:
- Interface: one clock (clk_in); reset is synchronous and active-low (rst).
- Reset values: all synchronisers = idle values (sck=0, cs=1, mosi=0); sample_delay_cnt=0; shift_reg=0; bit_cnt=0; rx_byte=0; tx_reg=0; spi_miso=0; led=2'b00.
- Reset mid-frame aborts the frame, clears all state, and produces no audit.
- Synchronisation: each input passes through SYNC_STAGES flip-flops. A further registered copy of SCK and CS gives edge detection (rise = sync & ~prev).
- All three inputs have equal synchroniser latency, so SCK/MOSI skew is preserved.
- Sampling: on a synchronised SCK rise while CS is low, sample_delay_cnt loads 1, then increments by 1 each clk_in.
- When the counter equals SAMPLE_DELAY, synchronised MOSI shifts into shift_reg LSB (left shift, MSB first), bit_cnt increments, and the counter returns to 0 (idle).
- MOSI changes after the capture cycle are ignored until the next SCK rise.
- SCK rise while the counter is non-zero: the pending bit is captured immediately in that cycle, then the counter reloads 1.
- Word completion: when bit_cnt reaches DATA_W, rx_byte is updated to the completed shift_reg value in the same cycle, bit_cnt wraps to 0, and a word_seen flag is set.
- Transmit: on a synchronised CS fall, tx_reg loads rx_byte, spi_miso = tx_reg[DATA_W-1], and bit_cnt, counter and word_seen are cleared.
- On each synchronised SCK fall with CS low, tx_reg shifts left and spi_miso takes the new MSB.
- While CS is high, spi_miso = 0.
- Audit, on a synchronised CS rise, evaluated after any capture pending in the same cycle:
  - bit_cnt != 0 → led = 2'b10 (partial word).
  - bit_cnt == 0 and word_seen → led = 2'b01.
  - No bits received → led = 2'b00.
- led holds its value until the next audit or reset.
- A capture still in progress at the CS rise is committed before the audit.
- CS high: the counter is forced to 0 and SCK edges are ignored.

Optional Feature:
- Macro: SPI_MAJORITY_VOTE_EN.
- Defined: the captured bit is the majority of synchronised MOSI at counter values SAMPLE_DELAY-1, SAMPLE_DELAY and SAMPLE_DELAY+1. Capture occurs at SAMPLE_DELAY+1, so total latency is +1 cycle versus the base design.
- Defined: SCK-rise-while-pending uses the votes collected so far, with ties resolving to the latest sample.
- Undefined: single sample at SAMPLE_DELAY as described above.

Test Plan:
- Skew capture: rst low 100 ns then high; CS low; SCK high; MOSI high 20 ns later; SCK low after 400 ns → sample_delay_cnt counts 1..4 after the synchronised SCK rise; shift_reg[0]=1 at count 4; bit_cnt=1; then CS high → led=2'b10.
- Full byte 0xA5, MOSI settled 20 ns after each SCK rise, 400 ns half-period → rx_byte=0xA5; CS high → led=2'b01.
- Echo: the frame after 0xA5 → spi_miso presents 1,0,1,0,0,1,0,1 (first bit valid after CS fall, then after each SCK fall); spi_miso=0 when CS high.
- Late glitch: MOSI toggles after the capture cycle but before SCK falls → captured bit unchanged.
- Reset mid-frame after 3 bits → all state cleared, led=2'b00, spi_miso=0; the next full frame is received correctly.
- Empty frame: CS low then high with no SCK → led=2'b00; a one-bit frame afterwards → led=2'b10.
